// File: rtl/pc_ir_unit.sv
// pc_ir_unit -- fetch-side datapath slice of the multicycle CPU.
//
// Holds the program counter (PC) and the instruction register (IR). It
// decodes IR into its instruction fields and carries out the PC-update
// strobes that the multicycle control FSM issues. This block has no FSM of
// its own. It only consumes the FSM's strobes.
//
// Strobe semantics: every input strobe is a level that is sampled on the
// rising clock edge. There is no valid/ready handshake. The control FSM must
// hold a strobe for exactly the cycles in which it wants the action to occur.
//
// Ports
//   clk, reset    single clock; synchronous active-high reset
//   IRWrite       load MemRdData into IR and capture PC+4 as LinkAddr
//   PCWrite       unconditional PC update
//   PCSrc         non-jump PCWrite source: 0 = ALUResult, 1 = ALUOut
//   BeqBranch     PC <= ALUOut when Zero = 1
//   BneBranch     PC <= ALUOut when Zero = 0
//   JumpCtrl      with PCWrite: jump-class update
//   JalCtrl       with JumpCtrl: 0 = J/JAL pseudo-direct target, 1 = JR (RegA)
//   Zero          ALU zero flag
//   ALUResult     combinational ALU result (PC+4 during fetch)
//   ALUOut        registered ALU result (branch target)
//   RegA          register-file A output (JR target)
//   MemRdData     instruction word from memory
//   PC, Instr     current PC and IR contents
//   Op, Funct     Instr[31:26], Instr[5:0]
//   Rs, Rt, Rd    Instr[25:21], Instr[20:16], Instr[15:11]
//   Shamt         Instr[10:6]
//   ImmSE, ImmZE  Instr[15:0], sign-extended or zero-extended
//   LinkAddr      PC+4 captured at the last IRWrite (used for JAL write-back)
//   InstrValid    set once IR has been loaded since reset
//   AddrErr       sticky misaligned-target flag
//
// Optional feature, guarded by the macro PC_ALIGN_CHECK_EN:
//   When the macro is defined, a selected PC next-value whose bits [1:0] are
//   non-zero is not loaded (PC holds), and AddrErr is set until reset.
//   When the macro is undefined, PC loads any value and AddrErr is tied to 0.

module pc_ir_unit #(
    parameter int                DATA_WIDTH = 32,
    parameter int                OP_WIDTH   = 6,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IRWrite,
    input  logic                  PCWrite,
    input  logic                  PCSrc,
    input  logic                  BeqBranch,
    input  logic                  BneBranch,
    input  logic                  JumpCtrl,
    input  logic                  JalCtrl,
    input  logic                  Zero,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] ALUOut,
    input  logic [DATA_WIDTH-1:0] RegA,
    input  logic [DATA_WIDTH-1:0] MemRdData,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [OP_WIDTH-1:0]   Op,
    output logic [OP_WIDTH-1:0]   Funct,
    output logic [4:0]            Rs,
    output logic [4:0]            Rt,
    output logic [4:0]            Rd,
    output logic [4:0]            Shamt,
    output logic [DATA_WIDTH-1:0] ImmSE,
    output logic [DATA_WIDTH-1:0] ImmZE,
    output logic [DATA_WIDTH-1:0] LinkAddr,
    output logic                  InstrValid,
    output logic                  AddrErr
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] link_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  pc_sel;
    logic [DATA_WIDTH-1:0] jump_target;

    // The pseudo-direct jump target is built from the IR contents before this
    // edge. A jump issued in the same cycle as a fetch therefore uses the old
    // instruction.
    assign jump_target = {pc_q[DATA_WIDTH-1:DATA_WIDTH-4], ir_q[25:0], 2'b00};

    // PC next-value selection. The checks run in priority order, highest
    // first. pc_sel marks the cycles in which any update is selected.
    always_comb begin
        pc_sel  = 1'b1;
        pc_next = pc_q;
        if (PCWrite && JumpCtrl && !JalCtrl) begin
            pc_next = jump_target;
        end else if (PCWrite && JumpCtrl) begin
            pc_next = RegA;
        end else if (PCWrite) begin
            pc_next = PCSrc ? ALUOut : ALUResult;
        end else if ((BeqBranch && Zero) || (BneBranch && !Zero)) begin
            pc_next = ALUOut;
        end else begin
            pc_sel = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic aerr_q;

    assign misaligned = pc_sel && (pc_next[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            aerr_q <= 1'b0;
        end else begin
            if (pc_sel && !misaligned) begin
                pc_q <= pc_next;
            end
            if (misaligned) begin
                aerr_q <= 1'b1;
            end
        end
    end

    assign AddrErr = aerr_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (pc_sel) begin
            pc_q <= pc_next;
        end
    end

    assign AddrErr = 1'b0;
`endif

    // Instruction register and the link address captured alongside it. At
    // fetch time the captured value is the PC of the next instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= '0;
            link_q  <= '0;
            valid_q <= 1'b0;
        end else if (IRWrite) begin
            ir_q    <= MemRdData;
            link_q  <= pc_q + DATA_WIDTH'(4);
            valid_q <= 1'b1;
        end
    end

    assign PC         = pc_q;
    assign Instr      = ir_q;
    assign LinkAddr   = link_q;
    assign InstrValid = valid_q;

    // The decode is purely combinational from IR and adds no latency.
    assign Op    = ir_q[31:26];
    assign Funct = ir_q[5:0];
    assign Rs    = ir_q[25:21];
    assign Rt    = ir_q[20:16];
    assign Rd    = ir_q[15:11];
    assign Shamt = ir_q[10:6];
    assign ImmSE = {{(DATA_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign ImmZE = {{(DATA_WIDTH-16){1'b0}}, ir_q[15:0]};

endmodule
